draw_sprite: RTL and testbench
==============================

# draw_sprite

Parametrised sprite overlay stage for the VGA pipeline, the successor to the fixed 48x64 rectangle drawer. It sits between two `vga_if` stages and overlays a WIDTH x HEIGHT sprite read from an external pixel ROM at a frame-latched position. It adds horizontal flip, colour-key transparency, multi-frame animation and a configurable ROM read latency, and delays all timing signals so they stay aligned with the merged RGB.

## Interface
Parameters:
- WIDTH, 48: sprite width in pixels (1..256).
- HEIGHT, 64: sprite height in pixels (1..256).
- ADDR_STRIDE, 64: ROM words per sprite row; must be at least WIDTH.
- FRAMES, 4: number of animation frames stored back to back in the ROM (1..16).
- FRAME_TICKS, 8: video frames per animation step (1..255).
- ROM_LATENCY, 1: cycles from `pixel_addr` to valid `rgb_pixel` (1..4).
- KEY_EN, 1: enables colour-key transparency.
- KEY_COLOR, 12'hF0F: transparent colour.
- ADDR_W, 16: width of `pixel_addr`; must cover FRAMES*HEIGHT*ADDR_STRIDE.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- vga_in  vga_if.in  -  upstream timing and background: hcount/vcount 11b, hsync, vsync, hblnk, vblnk, rgb 12b.
- vga_out  vga_if.out  -  delayed timing plus merged rgb.
- x_value  in  12  sprite left edge, screen coordinates.
- y_value  in  12  sprite top edge, screen coordinates.
- flip  in  1  1 = mirror the sprite horizontally.
- anim_en  in  1  1 = advance the animation frame.
- pixel_addr  out  ADDR_W  ROM read address.
- rgb_pixel  in  12  ROM data, valid ROM_LATENCY cycles after the address.

## Operation
- **Frame event:** the first cycle with `vga_in.vblnk`=1 after a cycle with `vga_in.vblnk`=0 (edge detect on a registered copy).
- **Latching:** on a frame event, `x_value`, `y_value` and `flip` are latched into x_l, y_l and flip_l. Only latched values are used during a frame, so there is no tearing.
- **Animation:**
  - On a frame event with `anim_en`=1, tick_cnt increments.
  - When tick_cnt reaches FRAME_TICKS-1, tick_cnt clears to 0 and frame_idx advances, wrapping from FRAMES-1 to 0.
  - With `anim_en`=0, tick_cnt and frame_idx hold.
- **Stage A (registered from vga_in):**
  - inbox = (hcount >= x_l) and (hcount <= x_l+WIDTH-1) and (vcount >= y_l) and (vcount <= y_l+HEIGHT-1) and (hblnk=0) and (vblnk=0).
  - Compares use 13-bit unsigned sums, so x_l+WIDTH does not wrap. A sprite that is partially or fully off-screen simply draws the visible part, or nothing.
  - dx = hcount-x_l; dy = vcount-y_l.
  - col = flip_l ? WIDTH-1-dx : dx.
  - `pixel_addr` = frame_idx*HEIGHT*ADDR_STRIDE + dy*ADDR_STRIDE + col, truncated to ADDR_W.
  - When inbox=0, `pixel_addr`=0.
- **Delay line:** inbox, hcount, vcount, hsync, vsync, hblnk, vblnk and background rgb travel through a ROM_LATENCY-deep shift register after stage A.
- **Output stage (registered):**
  - rgb = `rgb_pixel` if the delayed inbox=1 and not (KEY_EN and `rgb_pixel`==KEY_COLOR).
  - Otherwise rgb = the delayed background rgb.
  - All other `vga_out` fields are the delayed copies.

## Timing
- Latency from `vga_in` to `vga_out` is ROM_LATENCY+2 cycles for every field; the default is 3.
- `pixel_addr` is valid 1 cycle after the corresponding `vga_in` sample.
- `rgb_pixel` is sampled ROM_LATENCY cycles after that.
- Reset:
  - all `vga_out` fields 0, `pixel_addr` 0;
  - delay line, x_l, y_l and flip_l cleared;
  - frame_idx 0, tick_cnt 0, vblnk edge register 0.
- Reset mid-frame: outputs show 0 for ROM_LATENCY+2 cycles after release, then follow `vga_in`. The sprite is drawn at (0,0) until the next frame event.
- Changes to `x_value`/`y_value`/`flip` between frame events take effect only at the next frame event.
- Frame event coinciding with `anim_en` rising: that event counts as a tick.
- FRAMES=1: frame_idx stays 0.
- FRAME_TICKS=1: frame_idx advances on every frame event.

## Test plan
- **Basic draw:** reset, x=100, y=50, flip=0, one frame event, then pixel (100,50). Expect `pixel_addr`=0 one cycle later and `vga_out.rgb`=`rgb_pixel` ROM_LATENCY+2 cycles after input. Pixel (147,113) gives address 63*64+47=4079; pixel (148,50) passes the background through.
- **Flip:** flip=1 latched, pixel (100,50). Expect `pixel_addr`=47; pixel (147,50) gives 0.
- **Transparency:** ROM returns 12'hF0F in-box with background 12'h123. Expect output 12'h123; ROM 12'hF0E gives output 12'hF0E.
- **Animation:** anim_en=1, FRAME_TICKS=8, FRAMES=4. After 8 frame events, the address at the sprite origin is 1*64*64=4096. After 32 events it wraps back to 0. With anim_en=0 over 10 events, the address is unchanged.
- **Edges and latching:**
  - x=4090: nothing drawn, no false hit at hcount 0..37.
  - x=620 on a 640-wide screen: columns 620..639 drawn.
  - x_value changed mid-frame: no effect until the next vblnk rise.
- **Reset:** assert rst mid-line. Expect all outputs 0 on the next edge, and hsync/vsync alignment restored exactly ROM_LATENCY+2 cycles after release.

Source files
------------

// File: rtl/vga_if.sv
// VGA timing/colour bundle passed between pipeline stages.
// Carries counters, sync/blank strobes and 12-bit RGB.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/draw_sprite.sv
// Sprite overlay stage: ROM-backed sprite with flip, colour key and
// animation, merged over the upstream picture at a frame-latched position.
module draw_sprite #(
    parameter int          WIDTH       = 48,
    parameter int          HEIGHT      = 64,
    parameter int          ADDR_STRIDE = 64,
    parameter int          FRAMES      = 4,
    parameter int          FRAME_TICKS = 8,
    parameter int          ROM_LATENCY = 1,
    parameter int          KEY_EN      = 1,
    parameter logic [11:0] KEY_COLOR   = 12'hF0F,
    parameter int          ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    vga_if.in                 vga_in,
    vga_if.out                vga_out,
    input  logic [11:0]       x_value,
    input  logic [11:0]       y_value,
    input  logic              flip,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] pixel_addr,
    input  logic [11:0]       rgb_pixel
);

    localparam int FRAME_WORDS = HEIGHT * ADDR_STRIDE;

    typedef struct packed {
        logic        inbox;
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } pix_t;

    logic        vblnk_q;
    logic        frame_ev;
    logic [11:0] x_l;
    logic [11:0] y_l;
    logic        flip_l;
    logic [7:0]  tick_cnt;
    logic [3:0]  frame_idx;

    assign frame_ev = vga_in.vblnk & ~vblnk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q   <= 1'b0;
            x_l       <= '0;
            y_l       <= '0;
            flip_l    <= 1'b0;
            tick_cnt  <= '0;
            frame_idx <= '0;
        end else begin
            vblnk_q <= vga_in.vblnk;
            if (frame_ev) begin
                x_l    <= x_value;
                y_l    <= y_value;
                flip_l <= flip;
                if (anim_en) begin
                    if (tick_cnt == 8'(FRAME_TICKS - 1)) begin
                        tick_cnt <= '0;
                        if (frame_idx == 4'(FRAMES - 1))
                            frame_idx <= '0;
                        else
                            frame_idx <= frame_idx + 4'd1;
                    end else begin
                        tick_cnt <= tick_cnt + 8'd1;
                    end
                end
            end
        end
    end

    // 13-bit compares so a sprite near 4095 cannot wrap onto column 0
    logic [12:0]       hc13, vc13, x13, y13, x_end, y_end;
    logic              inbox_c;
    logic [7:0]        dx, dy, col;
    logic [ADDR_W-1:0] addr_c;
    pix_t              stage_c;

    always_comb begin
        hc13    = {2'b00, vga_in.hcount};
        vc13    = {2'b00, vga_in.vcount};
        x13     = {1'b0, x_l};
        y13     = {1'b0, y_l};
        x_end   = x13 + 13'(WIDTH - 1);
        y_end   = y13 + 13'(HEIGHT - 1);
        inbox_c = (hc13 >= x13) && (hc13 <= x_end) &&
                  (vc13 >= y13) && (vc13 <= y_end) &&
                  !vga_in.hblnk && !vga_in.vblnk;
        dx      = 8'(hc13 - x13);
        dy      = 8'(vc13 - y13);
        col     = flip_l ? (8'(WIDTH - 1) - dx) : dx;
        addr_c  = ADDR_W'(frame_idx) * ADDR_W'(FRAME_WORDS)
                + ADDR_W'(dy) * ADDR_W'(ADDR_STRIDE)
                + ADDR_W'(col);
        if (!inbox_c)
            addr_c = '0;
        stage_c.inbox  = inbox_c;
        stage_c.hcount = vga_in.hcount;
        stage_c.vcount = vga_in.vcount;
        stage_c.hsync  = vga_in.hsync;
        stage_c.vsync  = vga_in.vsync;
        stage_c.hblnk  = vga_in.hblnk;
        stage_c.vblnk  = vga_in.vblnk;
        stage_c.rgb    = vga_in.rgb;
    end

    pix_t a_q;
    pix_t dly [ROM_LATENCY];
    pix_t last;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            pixel_addr <= '0;
            for (int i = 0; i < ROM_LATENCY; i++)
                dly[i] <= '0;
        end else begin
            a_q        <= stage_c;
            pixel_addr <= addr_c;
            dly[0]     <= a_q;
            for (int i = 1; i < ROM_LATENCY; i++)
                dly[i] <= dly[i-1];
        end
    end

    assign last = dly[ROM_LATENCY-1];

    logic keyed;
    logic show;
    assign keyed = (KEY_EN != 0) && (rgb_pixel == KEY_COLOR);
    assign show  = last.inbox && !keyed;

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= last.hcount;
            vga_out.vcount <= last.vcount;
            vga_out.hsync  <= last.hsync;
            vga_out.vsync  <= last.vsync;
            vga_out.hblnk  <= last.hblnk;
            vga_out.vblnk  <= last.vblnk;
            vga_out.rgb    <= show ? rgb_pixel : last.rgb;
        end
    end

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite with a 1-cycle ROM model
// whose data is address[11:0] ^ 12'h5A5.
module tb_draw_sprite;

    localparam logic [11:0] BG = 12'h123;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] x_value, y_value;
    logic        flip, anim_en;
    logic [15:0] pixel_addr;
    logic [11:0] rgb_pixel;
    int          checks = 0;
    int          errors = 0;

    vga_if vin ();
    vga_if vout ();

    draw_sprite dut (
        .clk        (clk),
        .rst        (rst),
        .vga_in     (vin),
        .vga_out    (vout),
        .x_value    (x_value),
        .y_value    (y_value),
        .flip       (flip),
        .anim_en    (anim_en),
        .pixel_addr (pixel_addr),
        .rgb_pixel  (rgb_pixel)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        rgb_pixel <= pixel_addr[11:0] ^ 12'h5A5;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        vin.hcount = '0;
        vin.vcount = '0;
        vin.hsync  = 1'b0;
        vin.vsync  = 1'b0;
        vin.hblnk  = 1'b1;
        vin.vblnk  = 1'b0;
        vin.rgb    = BG;
    endtask

    task automatic frame_ev();
        @(negedge clk);
        vin.vblnk = 1'b1;
        @(negedge clk);
        vin.vblnk = 1'b0;
    endtask

    task automatic pix(input logic [10:0] hc, input logic [10:0] vc,
                       input logic [15:0] ea, input logic [11:0] er,
                       input string tag);
        @(negedge clk);
        vin.hcount = hc;
        vin.vcount = vc;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = BG;
        @(negedge clk);
        chk({tag, "/addr"}, 32'(pixel_addr), 32'(ea));
        idle();
        @(negedge clk);
        @(negedge clk);
        chk({tag, "/rgb"}, 32'(vout.rgb), 32'(er));
        chk({tag, "/hc"}, 32'(vout.hcount), 32'(hc));
    endtask

    initial begin
        rst = 1'b1;
        x_value = '0;
        y_value = '0;
        flip = 1'b0;
        anim_en = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst/rgb", 32'(vout.rgb), 0);
        chk("rst/hblnk", 32'(vout.hblnk), 0);
        chk("rst/hsync", 32'(vout.hsync), 0);
        chk("rst/addr", 32'(pixel_addr), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // basic draw and colour key
        x_value = 12'd100;
        y_value = 12'd50;
        frame_ev();
        pix(100, 50, 16'd0, 12'h5A5, "origin");
        pix(147, 113, 16'd4079, 12'hA4A, "corner");
        pix(148, 50, 16'd0, BG, "right_out");
        pix(142, 92, 16'd2730, BG, "key");
        pix(143, 92, 16'd2731, 12'hF0E, "nokey");

        // flip
        flip = 1'b1;
        frame_ev();
        pix(100, 50, 16'd47, 12'h58A, "flip_l");
        pix(147, 50, 16'd0, 12'h5A5, "flip_r");

        // mid-frame change has no effect until next frame event
        x_value = 12'd200;
        flip = 1'b0;
        pix(100, 50, 16'd47, 12'h58A, "hold");
        frame_ev();
        pix(200, 50, 16'd0, 12'h5A5, "moved");
        pix(100, 50, 16'd0, BG, "old_pos");

        // near the top of the coordinate range
        x_value = 12'd4090;
        frame_ev();
        pix(0, 50, 16'd0, BG, "wrap0");
        pix(37, 50, 16'd0, BG, "wrap37");

        // right screen edge
        x_value = 12'd620;
        frame_ev();
        pix(620, 50, 16'd0, 12'h5A5, "edge620");
        pix(639, 50, 16'd19, 12'h5B6, "edge639");
        pix(619, 50, 16'd0, BG, "edge619");

        // animation
        x_value = 12'd100;
        anim_en = 1'b1;
        repeat (8) frame_ev();
        pix(100, 50, 16'd4096, 12'h5A5, "anim8");
        repeat (8) frame_ev();
        pix(100, 50, 16'd8192, 12'h5A5, "anim16");
        repeat (16) frame_ev();
        pix(100, 50, 16'd0, 12'h5A5, "anim32");
        repeat (8) frame_ev();
        anim_en = 1'b0;
        repeat (10) frame_ev();
        pix(100, 50, 16'd4096, 12'h5A5, "anim_hold");

        // reset in the middle of an active line
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vin.hcount = 11'(300 + i);
            vin.vcount = 11'd10;
            vin.hblnk  = 1'b0;
            vin.hsync  = 1'b1;
            vin.vsync  = 1'b1;
        end
        chk("pre_rst/hsync", 32'(vout.hsync), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst/hsync", 32'(vout.hsync), 0);
        chk("mid_rst/vsync", 32'(vout.vsync), 0);
        chk("mid_rst/hc", 32'(vout.hcount), 0);
        chk("mid_rst/addr", 32'(pixel_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        vin.hcount = 11'd200;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) begin
                chk("rel/hsync0", 32'(vout.hsync), 0);
            end else begin
                chk("rel/hsync1", 32'(vout.hsync), 1);
                chk("rel/hc", 32'(vout.hcount), 200);
            end
            vin.hcount = 11'(200 + k);
        end
        idle();
        @(negedge clk);

        // position reverts to (0,0) until the next frame event
        pix(0, 0, 16'd0, 12'h5A5, "rst_org");
        pix(5, 3, 16'd197, 12'h560, "rst_pix");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
